// File: rtl/mult_sched.sv
// Round-robin scheduler sharing one multiplier between N_REQ requesters.
// Holds one transaction at a time: accept, issue, wait (with watchdog), respond.
module mult_sched #(
  parameter int N_REQ   = 2,
  parameter int WIDTH   = 8,
  parameter int TIMEOUT = 64
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [N_REQ-1:0]       req_valid,
  input  logic [N_REQ*WIDTH-1:0] req_a,
  input  logic [N_REQ*WIDTH-1:0] req_b,
  output logic [N_REQ-1:0]       req_ready,
  output logic                   mul_valid,
  output logic [WIDTH-1:0]       mul_a,
  output logic [WIDTH-1:0]       mul_b,
  input  logic                   mul_done,
  input  logic [2*WIDTH-1:0]     mul_result,
  output logic [N_REQ-1:0]       rsp_valid,
  output logic [2*WIDTH-1:0]     rsp_data,
  output logic                   rsp_err,
  input  logic [N_REQ-1:0]       rsp_ready,
  output logic                   busy
);

  localparam int IDX_W = $clog2(N_REQ);
  localparam int CNT_W = $clog2(TIMEOUT);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_t;

  state_t             state;
  logic [IDX_W-1:0]   rr_ptr;
  logic [IDX_W-1:0]   g;
  logic [IDX_W-1:0]   pick;
  logic               any_req;
  logic [WIDTH-1:0]   op_a;
  logic [WIDTH-1:0]   op_b;
  logic [2*WIDTH-1:0] res;
  logic               err;
  logic [CNT_W-1:0]   cnt;
  logic [WIDTH-1:0]   a_arr [N_REQ];
  logic [WIDTH-1:0]   b_arr [N_REQ];

  always_comb begin
    for (int i = 0; i < N_REQ; i++) begin
      a_arr[i] = req_a[i*WIDTH +: WIDTH];
      b_arr[i] = req_b[i*WIDTH +: WIDTH];
    end
  end

  // First pending requester at or above rr_ptr, wrapping around.
  // NOTE: every always_comb output gets a default before the loop so no latch is inferred.
  always_comb begin
    int               idx;
    logic [IDX_W-1:0] idx_v;
    any_req = 1'b0;
    pick    = rr_ptr;
    idx     = 0;
    idx_v   = '0;
    for (int i = 0; i < N_REQ; i++) begin
      idx = int'(rr_ptr) + i;
      if (idx >= N_REQ) idx = idx - N_REQ;
      idx_v = IDX_W'(idx);
      if (!any_req && req_valid[idx_v]) begin
        any_req = 1'b1;
        pick    = idx_v;
      end
    end
  end

  // Acceptance is combinational so the grant lands in the same IDLE cycle;
  // it is gated by rst_n so every output reads 0 while reset is held.
  assign req_ready = (rst_n && state == S_IDLE && any_req) ? (N_REQ'(1) << pick) : '0;
  assign mul_a     = op_a;
  assign mul_b     = op_b;
  assign rsp_data  = res;
  assign rsp_err   = err;

  // NOTE: sequential state uses non-blocking assignments only; mixing in blocking
  // writes here would create simulation/synthesis ordering mismatches.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      rr_ptr    <= '0;
      g         <= '0;
      op_a      <= '0;
      op_b      <= '0;
      res       <= '0;
      err       <= 1'b0;
      cnt       <= '0;
      mul_valid <= 1'b0;
      rsp_valid <= '0;
      busy      <= 1'b0;
    end else begin
      mul_valid <= 1'b0;
      unique case (state)
        S_IDLE: begin
          if (any_req) begin
            g         <= pick;
            op_a      <= a_arr[pick];
            op_b      <= b_arr[pick];
            mul_valid <= 1'b1;
            busy      <= 1'b1;
            state     <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          cnt   <= '0;
          state <= S_WAIT;
        end
        S_WAIT: begin
          cnt <= cnt + 1'b1;
          // A done arriving on the last watchdog cycle still counts as success.
          if (mul_done) begin
            res       <= mul_result;
            err       <= 1'b0;
            rsp_valid <= N_REQ'(1) << g;
            state     <= S_RESP;
          end else if (cnt == CNT_W'(TIMEOUT - 1)) begin
            res       <= '0;
            err       <= 1'b1;
            rsp_valid <= N_REQ'(1) << g;
            state     <= S_RESP;
          end
        end
        S_RESP: begin
          if (rsp_ready[g]) begin
            rsp_valid <= '0;
            rr_ptr    <= (g == IDX_W'(N_REQ - 1)) ? '0 : g + 1'b1;
            busy      <= 1'b0;
            state     <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mult_sched.sv
// Scoreboard bench for mult_sched: a behavioural multiplier answers mul_valid,
// accepted requests push expected responses, observed responses pop and compare.
module tb_mult_sched;

  localparam int N_REQ   = 2;
  localparam int WIDTH   = 8;
  localparam int TIMEOUT = 64;

  logic                   clk = 1'b0;
  logic                   rst_n = 1'b1;
  logic [N_REQ-1:0]       req_valid = '0;
  logic [N_REQ*WIDTH-1:0] req_a;
  logic [N_REQ*WIDTH-1:0] req_b;
  logic [N_REQ-1:0]       req_ready;
  logic                   mul_valid;
  logic [WIDTH-1:0]       mul_a;
  logic [WIDTH-1:0]       mul_b;
  logic                   mul_done = 1'b0;
  logic [2*WIDTH-1:0]     mul_result = '0;
  logic [N_REQ-1:0]       rsp_valid;
  logic [2*WIDTH-1:0]     rsp_data;
  logic                   rsp_err;
  logic [N_REQ-1:0]       rsp_ready = '0;
  logic                   busy;

  always #5 clk = ~clk;

  mult_sched #(.N_REQ(N_REQ), .WIDTH(WIDTH), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_a(req_a), .req_b(req_b), .req_ready(req_ready),
    .mul_valid(mul_valid), .mul_a(mul_a), .mul_b(mul_b),
    .mul_done(mul_done), .mul_result(mul_result),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_err(rsp_err),
    .rsp_ready(rsp_ready), .busy(busy)
  );

  logic signed [WIDTH-1:0] a_q [N_REQ];
  logic signed [WIDTH-1:0] b_q [N_REQ];

  always_comb begin
    for (int i = 0; i < N_REQ; i++) begin
      req_a[i*WIDTH +: WIDTH] = a_q[i];
      req_b[i*WIDTH +: WIDTH] = b_q[i];
    end
  end

  typedef struct {
    int                 idx;
    logic [2*WIDTH-1:0] data;
    logic               err;
  } exp_t;

  exp_t sb[$];
  int   grant_q[$];

  int vectors = 0, miscompares = 0;
  int cycle = 0, acc_cnt = 0, rsp_cnt = 0, mulv_cnt = 0, acc_cyc = 0, rsp_cyc = 0;
  logic             exp_err = 1'b0;
  logic             auto_rsp = 1'b1;
  logic [N_REQ-1:0] rsp_ready_man = '0;
  logic [N_REQ-1:0] prev_rsp = '0;
  logic [WIDTH-1:0] exp_ma = '0, exp_mb = '0;

  // Multiplier model knobs, written only by the stimulus process.
  int mul_lat = 18;
  bit mul_never = 1'b0;
  bit spurious = 1'b0;

  function automatic logic [2*WIDTH-1:0] smul(logic signed [WIDTH-1:0] a,
                                              logic signed [WIDTH-1:0] b);
    logic signed [2*WIDTH-1:0] x, y;
    x = a;
    y = b;
    return x * y;
  endfunction

  // Behavioural multiplier: done pulse mul_lat cycles after mul_valid.
  int                 cd = 0;
  logic [2*WIDTH-1:0] prod = '0;
  always begin
    @(posedge clk);
    #2;
    mul_done = 1'b0;
    if (!rst_n) cd = 0;
    else if (cd > 0) begin
      cd = cd - 1;
      if (cd == 0) begin
        mul_done   = 1'b1;
        mul_result = prod;
      end
    end
    if (spurious) begin
      mul_done   = 1'b1;
      mul_result = 16'h5A5A;
    end
    if (rst_n && mul_valid === 1'b1) begin
      prod = smul(mul_a, mul_b);
      if (!mul_never) cd = mul_lat;
    end
  end

  // One clock step: sample at the falling edge, return 1 time unit after the rising edge.
  task automatic tick();
    @(negedge clk);
    cycle++;
    if (rst_n) begin
      if (req_ready !== '0) begin
        int gi;
        gi = 0;
        for (int i = 0; i < N_REQ; i++) if (req_ready[i]) gi = i;
        vectors++;
        if (!$onehot(req_ready) || req_valid[gi] !== 1'b1) begin
          miscompares++;
          $display("FAIL grant_onehot: req_ready=%b req_valid=%b", req_ready, req_valid);
        end
        sb.push_back('{gi, exp_err ? '0 : smul(a_q[gi], b_q[gi]), exp_err});
        exp_ma = a_q[gi];
        exp_mb = b_q[gi];
        grant_q.push_back(gi);
        acc_cnt++;
        acc_cyc = cycle;
      end
      if (mul_valid === 1'b1) begin
        mulv_cnt++;
        vectors++;
        if (mul_a !== exp_ma || mul_b !== exp_mb) begin
          miscompares++;
          $display("FAIL mul_operands: got a=%h b=%h want a=%h b=%h", mul_a, mul_b, exp_ma, exp_mb);
        end
      end
      if (rsp_valid !== '0 && prev_rsp === '0) begin
        rsp_cnt++;
        rsp_cyc = cycle;
        vectors++;
        if (sb.size() == 0) begin
          miscompares++;
          $display("FAIL rsp_unexpected: rsp_valid=%b data=%h with nothing outstanding", rsp_valid, rsp_data);
        end else begin
          exp_t             e;
          logic [N_REQ-1:0] oh;
          e = sb.pop_front();
          oh = '0;
          oh[e.idx] = 1'b1;
          if (rsp_valid !== oh || rsp_data !== e.data || rsp_err !== e.err) begin
            miscompares++;
            $display("FAIL rsp_check: got valid=%b data=%h err=%b want valid=%b data=%h err=%b",
                     rsp_valid, rsp_data, rsp_err, oh, e.data, e.err);
          end
        end
      end
    end
    rsp_ready = auto_rsp ? rsp_valid : rsp_ready_man;
    prev_rsp  = rsp_valid;
    @(posedge clk);
    #1;
  endtask

  task automatic wait_acc(input int budget);
    int start, n;
    start = acc_cnt;
    n = 0;
    while (acc_cnt == start && n < budget) begin
      tick();
      n++;
    end
    vectors++;
    if (acc_cnt == start) begin
      miscompares++;
      $display("FAIL accept_timeout: no req_ready within %0d cycles", budget);
    end
  endtask

  task automatic wait_rsp(input int count, input int budget);
    int start, n;
    start = rsp_cnt;
    n = 0;
    while (rsp_cnt < start + count && n < budget) begin
      tick();
      n++;
    end
    vectors++;
    if (rsp_cnt < start + count) begin
      miscompares++;
      $display("FAIL rsp_timeout: got %0d of %0d responses in %0d cycles", rsp_cnt - start, count, budget);
    end
  endtask

  task automatic test_reset();
    for (int i = 0; i < N_REQ; i++) begin
      a_q[i] = '0;
      b_q[i] = '0;
    end
    req_valid = '1;
    #1 rst_n = 1'b0;
    #1;
    vectors++;
    if ({req_ready, mul_valid, mul_a, mul_b, rsp_valid, rsp_data, rsp_err, busy} !== '0) begin
      miscompares++;
      $display("FAIL reset_outputs: req_ready=%b mul_valid=%b busy=%b rsp_valid=%b (all should be 0)",
               req_ready, mul_valid, busy, rsp_valid);
    end
    repeat (2) @(posedge clk);
    #1;
    req_valid = '0;
    rst_n = 1'b1;
    tick();
    vectors++;
    if (busy !== 1'b0 || rsp_valid !== '0 || req_ready !== '0) begin
      miscompares++;
      $display("FAIL idle_after_reset: busy=%b rsp_valid=%b req_ready=%b want 0", busy, rsp_valid, req_ready);
    end
  endtask

  task automatic test_fairness();
    mul_lat = 3;
    exp_err = 1'b0;
    a_q[0] = -8'sd128; b_q[0] = -8'sd128;
    a_q[1] = 8'sd127;  b_q[1] = -8'sd1;
    grant_q.delete();
    req_valid = '1;
    wait_rsp(4, 200);
    req_valid = '0;
    vectors++;
    if (grant_q.size() != 4) begin
      miscompares++;
      $display("FAIL fair_count: got %0d grants want 4", grant_q.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        vectors++;
        if (grant_q[i] != i % 2) begin
          miscompares++;
          $display("FAIL fair_order[%0d]: got grant %0d want %0d", i, grant_q[i], i % 2);
        end
      end
    end
  endtask

  task automatic test_single();
    int mv0;
    tick();
    mul_lat = 18;
    a_q[0] = 8'sd3;
    b_q[0] = -8'sd2;
    mv0 = mulv_cnt;
    grant_q.delete();
    req_valid = 2'b01;
    wait_acc(10);
    req_valid = '0;
    vectors++;
    if (busy !== 1'b1 || mul_valid !== 1'b1) begin
      miscompares++;
      $display("FAIL issue_cycle: busy=%b mul_valid=%b want 1 1", busy, mul_valid);
    end
    wait_rsp(1, 100);
    vectors++;
    if (rsp_cyc - acc_cyc != 20) begin
      miscompares++;
      $display("FAIL single_latency: got %0d cycles want 20", rsp_cyc - acc_cyc);
    end
    vectors++;
    if (mulv_cnt - mv0 != 1) begin
      miscompares++;
      $display("FAIL mul_valid_pulses: got %0d want 1", mulv_cnt - mv0);
    end
    vectors++;
    if (busy !== 1'b0 || rsp_valid !== '0) begin
      miscompares++;
      $display("FAIL back_to_idle: busy=%b rsp_valid=%b want 0", busy, rsp_valid);
    end
  endtask

  task automatic test_watchdog();
    mul_never = 1'b1;
    exp_err = 1'b1;
    a_q[0] = 8'sd5;
    b_q[0] = 8'sd7;
    req_valid = 2'b01;
    wait_acc(10);
    req_valid = '0;
    wait_rsp(1, TIMEOUT + 20);
    vectors++;
    if (rsp_cyc - acc_cyc != TIMEOUT + 2) begin
      miscompares++;
      $display("FAIL abort_latency: got %0d cycles want %0d", rsp_cyc - acc_cyc, TIMEOUT + 2);
    end
    mul_never = 1'b0;
    exp_err = 1'b0;
    mul_lat = 5;
    a_q[1] = -8'sd3;
    b_q[1] = 8'sd9;
    req_valid = 2'b10;
    wait_acc(10);
    req_valid = '0;
    wait_rsp(1, 50);
    vectors++;
    if (rsp_cyc - acc_cyc != 7) begin
      miscompares++;
      $display("FAIL post_abort_latency: got %0d cycles want 7", rsp_cyc - acc_cyc);
    end
  endtask

  task automatic test_simultaneous();
    int r0;
    mul_lat = TIMEOUT;
    a_q[0] = -8'sd7;
    b_q[0] = 8'sd6;
    req_valid = 2'b01;
    wait_acc(10);
    req_valid = '0;
    wait_rsp(1, TIMEOUT + 20);
    vectors++;
    if (rsp_cyc - acc_cyc != TIMEOUT + 2) begin
      miscompares++;
      $display("FAIL tie_latency: got %0d cycles want %0d", rsp_cyc - acc_cyc, TIMEOUT + 2);
    end
    tick();
    r0 = rsp_cnt;
    spurious = 1'b1;
    tick();
    spurious = 1'b0;
    repeat (4) begin
      tick();
      vectors++;
      if (rsp_valid !== '0 || busy !== 1'b0 || mul_valid !== 1'b0) begin
        miscompares++;
        $display("FAIL spurious_done: rsp_valid=%b busy=%b mul_valid=%b want 0", rsp_valid, busy, mul_valid);
      end
    end
    vectors++;
    if (rsp_cnt != r0) begin
      miscompares++;
      $display("FAIL spurious_rsp_count: got %0d extra responses want 0", rsp_cnt - r0);
    end
  endtask

  task automatic test_backpressure();
    logic [2*WIDTH-1:0] want;
    int a0;
    auto_rsp = 1'b0;
    rsp_ready_man = '0;
    mul_lat = 4;
    a_q[0] = 8'sd10;  b_q[0] = -8'sd10;
    a_q[1] = 8'sd2;   b_q[1] = 8'sd2;
    want = smul(8'sd10, -8'sd10);
    grant_q.delete();
    req_valid = 2'b01;
    wait_acc(10);
    req_valid = 2'b10;
    wait_rsp(1, 50);
    a0 = acc_cnt;
    rsp_ready_man = 2'b10;
    for (int i = 0; i < 10; i++) begin
      vectors++;
      if (rsp_valid !== 2'b01 || rsp_data !== want || rsp_err !== 1'b0 || req_ready !== '0) begin
        miscompares++;
        $display("FAIL hold[%0d]: rsp_valid=%b data=%h err=%b req_ready=%b want 01 %h 0 00",
                 i, rsp_valid, rsp_data, rsp_err, req_ready, want);
      end
      tick();
    end
    vectors++;
    if (acc_cnt != a0) begin
      miscompares++;
      $display("FAIL accept_during_resp: got %0d acceptances want 0", acc_cnt - a0);
    end
    rsp_ready_man = 2'b01;
    tick();
    rsp_ready_man = '0;
    auto_rsp = 1'b1;
    wait_acc(10);
    req_valid = '0;
    vectors++;
    if (grant_q[grant_q.size() - 1] != 1) begin
      miscompares++;
      $display("FAIL bp_next_grant: got %0d want 1", grant_q[grant_q.size() - 1]);
    end
    wait_rsp(1, 50);
  endtask

  task automatic test_reset_mid();
    int r0;
    mul_lat = 30;
    a_q[0] = 8'sd4;
    b_q[0] = 8'sd4;
    req_valid = 2'b01;
    wait_acc(10);
    req_valid = '0;
    repeat (5) tick();
    req_valid = '1;
    rst_n = 1'b0;
    #1;
    vectors++;
    if ({req_ready, mul_valid, mul_a, mul_b, rsp_valid, rsp_data, rsp_err, busy} !== '0) begin
      miscompares++;
      $display("FAIL mid_reset_outputs: req_ready=%b mul_a=%h mul_b=%h busy=%b (all should be 0)",
               req_ready, mul_a, mul_b, busy);
    end
    tick();
    sb.delete();
    grant_q.delete();
    mul_lat = 5;
    a_q[0] = -8'sd1;
    b_q[0] = -8'sd1;
    r0 = rsp_cnt;
    rst_n = 1'b1;
    wait_acc(10);
    req_valid = '0;
    vectors++;
    if (grant_q.size() == 0 || grant_q[0] != 0) begin
      miscompares++;
      $display("FAIL post_reset_grant: got %0d want 0", grant_q.size() ? grant_q[0] : -1);
    end
    wait_rsp(1, 50);
    repeat (40) tick();
    vectors++;
    if (rsp_cnt != r0 + 1) begin
      miscompares++;
      $display("FAIL aborted_rsp: got %0d responses after reset want 1", rsp_cnt - r0);
    end
  endtask

  initial begin
    test_reset();
    test_fairness();
    test_single();
    test_watchdog();
    test_simultaneous();
    test_backpressure();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation exceeded time limit");
    $fatal(1, "time limit");
  end

endmodule
